clock_phase_voter: RTL and testbench

CLOCK_PHASE_VOTER -- requirements
Module: clock_phase_voter

---
 rtl/clock_sync_pkg.sv | 28 ++
 rtl/sample_accumulator.sv | 74 +++++++
 rtl/clock_phase_voter.sv | 160 ++++++++++++++++
 tb/tb_clock_phase_voter.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/clock_sync_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clock_sync_pkg
// Description : Shared types, default parameters and width helper for the
//               clock synchronisation controller and the phase voter.
// Revision    : 1.0 - initial release
// ============================================================================
package clock_sync_pkg;

   // Voter state encoding; all four codes of the 2-bit space are named.
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SETTLE  = 2'd1,
      ST_COLLECT = 2'd2,
      ST_DONE    = 2'd3
   } voter_state_e;

   localparam int c_NUM_SAMPLES_DEF   = 16;
   localparam int c_SETTLE_CYCLES_DEF = 4;
   localparam int c_TOLERANCE_DEF     = 1;

   // Bits needed to hold a count from 0 up to and including n.
   function automatic int cw_of(input int n);
      return $clog2(n + 1);
   endfunction

endpackage : clock_sync_pkg
`default_nettype wire

// File: rtl/sample_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : sample_accumulator
// Description : Saturating sample/ones counters plus the majority and
//               disagreement vote computed from the accumulated ones.
// Revision    : 1.0 - initial release
// ============================================================================
module sample_accumulator
   import clock_sync_pkg::*;
#(
   parameter int NUM_SAMPLES = c_NUM_SAMPLES_DEF,
   parameter int TOLERANCE   = c_TOLERANCE_DEF
) (
   input  logic                             clock,
   input  logic                             reset_n,
   input  logic                             clear_i,
   input  logic                             enable_i,
   input  logic                             bit_i,
   output logic [cw_of(NUM_SAMPLES)-1:0]    ones_o,
   output logic [cw_of(NUM_SAMPLES)-1:0]    count_o,
   output logic                             done_o,
   output logic                             majority_o,
   output logic                             error_o
);

   localparam int            CW     = cw_of(NUM_SAMPLES);
   localparam logic [CW-1:0] c_FULL = CW'(NUM_SAMPLES);
   localparam logic [CW-1:0] c_ONE  = CW'(1);

   logic [CW-1:0] ones_q, ones_d;
   logic [CW-1:0] count_q, count_d;
   int            n_ones, n_zeros, n_minor;

   // Next counter values: clear wins, counting stops once the window is full.
   always_comb begin
      ones_d  = ones_q;
      count_d = count_q;
      if (clear_i) begin
         ones_d  = '0;
         count_d = '0;
      end else if (enable_i && (count_q < c_FULL)) begin
         count_d = count_q + c_ONE;
         if (bit_i) begin
            ones_d = ones_q + c_ONE;
         end
      end
   end

   // Counter registers.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         ones_q  <= '0;
         count_q <= '0;
      end else begin
         ones_q  <= ones_d;
         count_q <= count_d;
      end
   end

   // Vote on the accumulated ones; a tie resolves to 1.
   always_comb begin
      n_ones     = int'(ones_q);
      n_zeros    = NUM_SAMPLES - n_ones;
      n_minor    = (n_ones < n_zeros) ? n_ones : n_zeros;
      majority_o = ((2 * n_ones) >= NUM_SAMPLES);
      error_o    = (n_minor > TOLERANCE);
   end

   assign ones_o  = ones_q;
   assign count_o = count_q;
   assign done_o  = (count_q == c_FULL);

endmodule : sample_accumulator
`default_nettype wire

// File: rtl/clock_phase_voter.sv
`default_nettype none
// ============================================================================
// Module      : clock_phase_voter
// Description : Samples an asynchronous clock (din) with one phase clock,
//               discards a settle window, then majority-votes NUM_SAMPLES
//               retimed samples per request and holds the result.
// Revision    : 1.0 - initial release
// ============================================================================
module clock_phase_voter
   import clock_sync_pkg::*;
#(
   parameter int NUM_SAMPLES   = c_NUM_SAMPLES_DEF,
   parameter int SETTLE_CYCLES = c_SETTLE_CYCLES_DEF,
   parameter int TOLERANCE     = c_TOLERANCE_DEF
) (
   input  logic                             clock,
   input  logic                             reset_n,
   input  logic                             din,
   input  logic                             sample_req,
   output logic                             dout,
   output logic                             sample_valid,
   output logic                             sample_error,
   output logic                             sample_idle,
   output logic [cw_of(NUM_SAMPLES)-1:0]    ones_count
);

   localparam int            CW            = cw_of(NUM_SAMPLES);
   localparam logic [3:0]    c_SETTLE_LAST = 4'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

   (* IOB = "TRUE" *) logic capture_q;
   logic          retime_q;

   voter_state_e  state_q, state_d;
   logic [3:0]    settle_q, settle_d;
   logic          dout_q, dout_d;
   logic          valid_q, valid_d;
   logic          error_q, error_d;
   logic          idle_q, idle_d;
   logic [CW-1:0] ones_q, ones_d;
   logic          acc_clear, acc_en;

   logic [CW-1:0] w_ones, w_count;
   logic          w_done, w_majority, w_error;

   // Pad capture flop followed by one retiming flop; only the retimed bit is voted.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         capture_q <= 1'b0;
         retime_q  <= 1'b0;
      end else begin
         capture_q <= din;
         retime_q  <= capture_q;
      end
   end

   sample_accumulator #(
      .NUM_SAMPLES (NUM_SAMPLES),
      .TOLERANCE   (TOLERANCE)
   ) u_acc (
      .clock      (clock),
      .reset_n    (reset_n),
      .clear_i    (acc_clear),
      .enable_i   (acc_en),
      .bit_i      (retime_q),
      .ones_o     (w_ones),
      .count_o    (w_count),
      .done_o     (w_done),
      .majority_o (w_majority),
      .error_o    (w_error)
   );

   // Next state, counter control and result capture on DONE entry.
   always_comb begin
      state_d   = state_q;
      settle_d  = settle_q;
      dout_d    = dout_q;
      valid_d   = valid_q;
      error_d   = error_q;
      ones_d    = ones_q;
      acc_clear = 1'b0;
      acc_en    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (sample_req) begin
               acc_clear = 1'b1;
               settle_d  = 4'd0;
               state_d   = (SETTLE_CYCLES == 0) ? ST_COLLECT : ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (!sample_req) begin
               state_d = ST_IDLE;
            end else if (settle_q == c_SETTLE_LAST) begin
               state_d = ST_COLLECT;
            end else begin
               settle_d = settle_q + 4'd1;
            end
         end
         ST_COLLECT: begin
            if (!sample_req) begin
               state_d = ST_IDLE;
            end else if (w_done) begin
               state_d = ST_DONE;
               dout_d  = w_majority;
               error_d = w_error;
               ones_d  = w_ones;
               valid_d = 1'b1;
            end else begin
               acc_en = 1'b1;
            end
         end
         ST_DONE: begin
            if (!sample_req) begin
               state_d = ST_IDLE;
               valid_d = 1'b0;
               error_d = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
            error_d = 1'b0;
         end
      endcase
      idle_d = (state_d == ST_IDLE);
   end

   // State and result registers; reset overrides every transition.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         settle_q <= 4'd0;
         dout_q   <= 1'b0;
         valid_q  <= 1'b0;
         error_q  <= 1'b0;
         idle_q   <= 1'b1;
         ones_q   <= '0;
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
         dout_q   <= dout_d;
         valid_q  <= valid_d;
         error_q  <= error_d;
         idle_q   <= idle_d;
         ones_q   <= ones_d;
      end
   end

   // The sample counter must never run past the vote window.
   a_count_bound : assert property (@(posedge clock) disable iff (!reset_n)
      int'(w_count) <= NUM_SAMPLES);

   assign dout         = dout_q;
   assign sample_valid = valid_q;
   assign sample_error = error_q;
   assign sample_idle  = idle_q;
   assign ones_count   = ones_q;

endmodule : clock_phase_voter
`default_nettype wire

// File: tb/tb_clock_phase_voter.sv
`default_nettype none
// ============================================================================
// Module      : tb_clock_phase_voter
// Description : Self-checking bench for clock_phase_voter with randomized
//               sample patterns and a behavioural vote model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_phase_voter;

   localparam int N   = 16;
   localparam int S   = 4;
   localparam int TOL = 1;
   localparam int LAT = 1 + S + N;

   logic       clock;
   logic       reset_n;
   logic       din;
   logic       sample_req;
   logic       dout;
   logic       sample_valid;
   logic       sample_error;
   logic       sample_idle;
   logic [4:0] ones_count;

   int         n_cmp;
   int         n_err;
   logic       exp_dout;
   int         exp_ones;

   clock_phase_voter #(
      .NUM_SAMPLES   (N),
      .SETTLE_CYCLES (S),
      .TOLERANCE     (TOL)
   ) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .din          (din),
      .sample_req   (sample_req),
      .dout         (dout),
      .sample_valid (sample_valid),
      .sample_error (sample_error),
      .sample_idle  (sample_idle),
      .ones_count   (ones_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Advance one active edge and settle just after it.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check_retained(input string tag);
      check_eq({tag, "_dout"}, dout, exp_dout);
      check_eq({tag, "_ones"}, ones_count, exp_ones);
   endtask

   // Full vote. Sample j of the window is the din value present at edge
   // e0+S-1+j: two flops of latency ahead of the N collect edges.
   task automatic run_vote(input logic [N-1:0] pat, input int hold);
      int   ones;
      logic e_dout, e_err;
      ones   = $countones(pat);
      e_dout = ((2 * ones) >= N);
      e_err  = (((ones < N - ones) ? ones : N - ones) > TOL);
      sample_req = 1'b1;
      for (int k = 0; k <= LAT; k++) begin
         if (k >= S - 1 && k <= S - 2 + N) din = pat[k - S + 1];
         else                              din = 1'($urandom);
         tick();
         if (k < LAT) begin
            check_eq("valid_early", sample_valid, 1'b0);
            check_eq("idle_busy", sample_idle, 1'b0);
            check_retained("hold_prev");
         end
      end
      check_eq("valid_at_lat", sample_valid, 1'b1);
      check_eq("vote_dout", dout, e_dout);
      check_eq("vote_error", sample_error, e_err);
      check_eq("vote_ones", ones_count, ones);
      check_eq("idle_done", sample_idle, 1'b0);
      exp_dout = e_dout;
      exp_ones = ones;
      for (int h = 0; h < hold; h++) begin
         din = 1'($urandom);
         tick();
         check_eq("done_valid", sample_valid, 1'b1);
         check_eq("done_error", sample_error, e_err);
         check_retained("done_stable");
      end
      sample_req = 1'b0;
      tick();
      check_eq("drop_valid", sample_valid, 1'b0);
      check_eq("drop_error", sample_error, 1'b0);
      check_eq("drop_idle", sample_idle, 1'b1);
      check_retained("after_done");
   endtask

   // Request held for edges 0..last, sampled low at edge last+1 -> abort.
   task automatic run_abort(input int last);
      sample_req = 1'b1;
      for (int k = 0; k <= last; k++) begin
         din = 1'($urandom);
         tick();
         check_eq("abort_valid", sample_valid, 1'b0);
         check_eq("abort_busy", sample_idle, 1'b0);
      end
      sample_req = 1'b0;
      din = 1'($urandom);
      tick();
      check_eq("abort_idle", sample_idle, 1'b1);
      check_eq("abort_novalid", sample_valid, 1'b0);
      check_retained("abort_keep");
   endtask

   // Reset asserted so it is sampled at edge at_edge of a vote.
   task automatic run_reset(input int at_edge);
      sample_req = 1'b1;
      for (int k = 0; k < at_edge; k++) begin
         din = 1'($urandom);
         tick();
         check_eq("pre_rst_valid", sample_valid, (k >= LAT) ? 1'b1 : 1'b0);
      end
      reset_n = 1'b0;
      tick();
      check_eq("rst_valid", sample_valid, 1'b0);
      check_eq("rst_error", sample_error, 1'b0);
      check_eq("rst_idle", sample_idle, 1'b1);
      check_eq("rst_dout", dout, 1'b0);
      check_eq("rst_ones", ones_count, 0);
      exp_dout = 1'b0;
      exp_ones = 0;
      sample_req = 1'b0;
      reset_n    = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check_eq("post_rst_valid", sample_valid, 1'b0);
         check_eq("post_rst_idle", sample_idle, 1'b1);
      end
   endtask

   initial begin
      logic [N-1:0] p;
      n_cmp      = 0;
      n_err      = 0;
      exp_dout   = 1'b0;
      exp_ones   = 0;
      reset_n    = 1'b0;
      sample_req = 1'b0;
      din        = 1'b0;
      tick();
      tick();
      check_eq("reset_idle", sample_idle, 1'b1);
      check_eq("reset_valid", sample_valid, 1'b0);
      check_eq("reset_error", sample_error, 1'b0);
      check_retained("reset");
      reset_n = 1'b1;
      tick();
      check_eq("idle_after_rst", sample_idle, 1'b1);

      run_vote(16'hFFFF, 2);                  // unanimous ones
      run_vote(16'h01FF, 0);                  // 9 ones, 7 zeros
      run_vote(16'hFFFF ^ 16'h0100, 1);       // one zero
      run_vote(16'h00FF, 3);                  // tie
      run_vote(16'h0000, 1);                  // unanimous zeros
      run_vote(16'h0010, 0);                  // one stray one
      run_vote(16'h8001, 2);                  // two ones
      run_abort(10);
      run_reset(15);
      run_vote(16'hFFFF, 1);
      run_reset(LAT + 2);                     // reset while holding DONE
      run_vote(16'hA5A5, 0);

      for (int i = 0; i < 30; i++) begin
         case ($urandom_range(0, 3))
            0: p = N'($urandom);
            1: p = ~(N'(1) << $urandom_range(0, N - 1));
            2: p = (N'(1) << $urandom_range(0, N - 1)) | (N'(1) << $urandom_range(0, N - 1));
            default: p = ~N'($urandom) & N'($urandom);
         endcase
         if ($urandom_range(0, 4) == 0) run_abort($urandom_range(0, LAT - 1));
         else                           run_vote(p, $urandom_range(0, 3));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_clock_phase_voter
`default_nettype wire
